stage3_pixel_writer: RTL and testbench

Final stage of the bilinear downscaling pipeline: consumes the Q8.8 pixel stream produced by the Y-interpolation stage (`p_final`, `valid`), converts each sample to an 8-bit pixel and packs four pixels per 32-bit word. It then writes the words sequentially into the output image memory starting at a programmable base address, and signals completion after a programmed pixel count. It has no backpressure toward the pipeline: it must sustain one pixel per cycle.

---
 rtl/stage3_pixel_writer.sv | 214 +++++++++++++++++++++
 tb/tb_stage3_pixel_writer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_pixel_writer.sv
// stage3_pixel_writer: final stage of the bilinear downscaler.
// Converts the Q8.8 pixel stream to 8-bit pixels, packs four per 32-bit
// word and writes the words sequentially from a programmable base address.
// It has no backpressure, so it accepts one pixel per cycle.
// Optional feature macro: PIXEL_ROUND_NEAREST_EN
//   defined   -> pixel = sat255((q + 0x80) >> 8)   (round half up)
//   undefined -> pixel = q[15:8]                   (truncation)
module stage3_pixel_writer #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [CNT_W-1:0]  i_num_pixels,
   input  logic [15:0]       i_p_final_q,
   input  logic              i_valid,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_be,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_drop
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   // Frame context captured on an accepted start.
   logic [ADDR_W-1:0] word_addr;    // address the next word will be written to
   logic [CNT_W-1:0]  num_latched;  // pixels in the current frame
   logic [CNT_W-1:0]  pix_cnt;      // pixels accepted so far in this frame
   logic              zero_frame;   // current frame had a pixel count of zero

   // Packing state: lanes 0..2 are buffered; lane 3 always completes a word,
   // so it never needs storage.
   logic [1:0]  lane;
   logic [23:0] word_buf;

   // Per-cycle decisions.
   logic        start_ok;
   logic        accept;
   logic        last_pix;
   logic        write_now;

   // Datapath intermediates.
   logic [16:0] sum17;
   logic [7:0]  pix8;
   logic [31:0] word_merged;
   logic [3:0]  be_now;

   // Pixel conversion: 17-bit sum keeps the rounding carry before saturation.
   always_comb begin
`ifdef PIXEL_ROUND_NEAREST_EN
      sum17 = {1'b0, i_p_final_q} + 17'h0_0080;
`else
      sum17 = {1'b0, i_p_final_q};
`endif
      // A sum at or above 0x10000 means the shifted value exceeds 255.
      pix8 = (sum17 > 17'h0_FFFF) ? 8'hFF : sum17[15:8];
   end

   // Merge the incoming pixel into its lane; lanes above it stay zero
   // because the buffer is cleared after every write.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      word_merged = {8'h00, word_buf};
      case (lane)
         2'd0:    word_merged[7:0]   = pix8;
         2'd1:    word_merged[15:8]  = pix8;
         2'd2:    word_merged[23:16] = pix8;
         default: word_merged[31:24] = pix8;
      endcase
      be_now = {lane == 2'd3, lane >= 2'd2, lane >= 2'd1, 1'b1};
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_next = state;
      start_ok   = 1'b0;
      accept     = 1'b0;
      last_pix   = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               start_ok   = 1'b1;
               state_next = (i_num_pixels == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (i_valid) begin
               accept = 1'b1;
               if (pix_cnt == num_latched - CNT_W'(1)) begin
                  last_pix   = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A word goes out when lane 3 fills or the frame's last pixel arrives.
   assign write_now = accept && ((lane == 2'd3) || last_pix);

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame context: base address, pixel count and progress counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_addr   <= '0;
         num_latched <= '0;
         pix_cnt     <= '0;
         zero_frame  <= 1'b0;
      end else if (start_ok) begin
         word_addr   <= i_base_addr;
         num_latched <= i_num_pixels;
         pix_cnt     <= '0;
         zero_frame  <= (i_num_pixels == '0);
      end else if (accept) begin
         pix_cnt <= pix_cnt + CNT_W'(1);
         if (write_now) begin
            // Wraps modulo 2^ADDR_W by construction.
            word_addr <= word_addr + ADDR_W'(1);
         end
      end
   end

   // Lane packing buffer; a reset or new frame discards any partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane     <= 2'd0;
         word_buf <= '0;
      end else if (start_ok) begin
         lane     <= 2'd0;
         word_buf <= '0;
      end else if (accept) begin
         if (write_now) begin
            lane     <= 2'd0;
            word_buf <= '0;
         end else begin
            lane     <= lane + 2'd1;
            word_buf <= word_merged[23:0];
         end
      end
   end

   // Registered memory write port; address/data/enables hold between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_be    <= '0;
      end else begin
         o_mem_we <= write_now;
         if (write_now) begin
            o_mem_addr  <= word_addr;
            o_mem_wdata <= word_merged;
            o_mem_be    <= be_now;
         end
      end
   end

   // Status outputs: busy tracks RUN, done pulses once per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_busy <= (state_next == RUN);
         // Normal frames pulse one cycle after the final write (the cycle
         // after DONE); an empty frame pulses right after its start.
         o_done <= (start_ok && (i_num_pixels == '0)) ||
                   ((state == DONE) && !zero_frame);
      end
   end

   // Sticky drop flag: pixels outside RUN, including the start cycle itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_drop <= 1'b0;
      end else if (start_ok) begin
         // The start clears the flag, but a pixel in that same cycle is
         // itself dropped and re-arms it.
         o_drop <= i_valid;
      end else if (i_valid && (state != RUN)) begin
         o_drop <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stage3_pixel_writer.sv
// Self-checking bench for stage3_pixel_writer: conversion vector table,
// hand-written corner sequences and random frames checked against a
// frame-level reference model.
module tb_stage3_pixel_writer;

   localparam int ADDR_W = 16;
   localparam int CNT_W  = 18;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_start;
   logic [ADDR_W-1:0] i_base_addr;
   logic [CNT_W-1:0]  i_num_pixels;
   logic [15:0]       i_p_final_q;
   logic              i_valid;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata;
   logic [3:0]        o_mem_be;
   logic              o_busy;
   logic              o_done;
   logic              o_drop;

   stage3_pixel_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_num_pixels(i_num_pixels),
      .i_p_final_q (i_p_final_q),
      .i_valid     (i_valid),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_be    (o_mem_be),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_drop      (o_drop)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  exp;
   } conv_vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   int  cyc = 0;
   wr_t wr_q[$];
   int  last_wr_cyc = 0;
   bit  busy_at_last_wr = 1'b0;
   int  done_cyc = 0;
   int  done_count = 0;

   logic [15:0] stim_vals[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Write/done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (o_mem_we) begin
         wr_q.push_back('{addr: o_mem_addr, data: o_mem_wdata, be: o_mem_be});
         last_wr_cyc = cyc;
         busy_at_last_wr = o_busy;
      end
      if (o_done) begin
         done_cyc = cyc;
         done_count++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference conversion from Q8.8 to an 8-bit pixel.
   function automatic logic [7:0] ref_pixel(input logic [15:0] q);
      int v;
`ifdef PIXEL_ROUND_NEAREST_EN
      v = (int'(q) + 128) / 256;
`else
      v = int'(q) / 256;
`endif
      if (v > 255) v = 255;
      return v[7:0];
   endfunction

   // Runs one frame: start, feed stim_vals[0..count-1], wait for done, then
   // compare the captured writes and timing against the frame model.
   task automatic run_frame(input logic [15:0] base, input int count,
                            input int mode, input bit start_valid);
      int sent, k, to, done0, start_cyc, last_drive_cyc, nw, idx;
      bit v;
      logic [31:0] ed;
      logic [3:0]  eb;
      logic [15:0] ea;
      wr_q.delete();
      done0 = done_count;
      @(negedge clk);
      start_cyc    = cyc;
      i_start      = 1'b1;
      i_base_addr  = base;
      i_num_pixels = 18'(count);
      i_valid      = start_valid;
      i_p_final_q  = 16'hABCD;
      @(negedge clk);
      i_start = 1'b0;
      i_valid = 1'b0;
      #1;
      check("busy after start", o_busy, (count != 0));
      sent = 0;
      k = 0;
      last_drive_cyc = 0;
      while (sent < count) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (k % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         i_valid = v;
         if (v) begin
            i_p_final_q = stim_vals[sent];
            last_drive_cyc = cyc;
            sent++;
         end
         k++;
         @(negedge clk);
      end
      i_valid = 1'b0;
      #1;
      to = 0;
      while (done_count == done0 && to < 200) begin
         @(negedge clk);
         #1;
         to++;
      end
      check("done seen", (done_count != done0), 1);
      nw = (count + 3) / 4;
      check("write count", wr_q.size(), nw);
      for (int w = 0; w < nw && w < wr_q.size(); w++) begin
         ed = '0;
         eb = '0;
         for (int l = 0; l < 4; l++) begin
            idx = 4 * w + l;
            if (idx < count) begin
               ed = ed | (32'(ref_pixel(stim_vals[idx])) << (8 * l));
               eb[l] = 1'b1;
            end
         end
         ea = 16'(int'(base) + w);
         check("write addr", wr_q[w].addr, ea);
         check("write data", wr_q[w].data, ed);
         check("write be", wr_q[w].be, eb);
      end
      if (count > 0) begin
         check("write latency", last_wr_cyc, last_drive_cyc + 1);
         check("busy low at final write", busy_at_last_wr, 0);
         check("done after final write", done_cyc, last_wr_cyc + 1);
      end else begin
         check("done after empty start", done_cyc, start_cyc + 1);
      end
      check("drop after frame", o_drop, start_valid);
      @(negedge clk);
      #1;
      check("done is a pulse", o_done, 0);
      check("busy idle", o_busy, 0);
   endtask

   initial begin
      conv_vec_t vecs[8];
      logic [15:0] b;
      int cnt;

`ifdef PIXEL_ROUND_NEAREST_EN
      vecs[0] = '{16'h1280, 8'h13};
      vecs[1] = '{16'hFFC0, 8'hFF};
      vecs[2] = '{16'h0000, 8'h00};
      vecs[3] = '{16'h007F, 8'h00};
      vecs[4] = '{16'h0080, 8'h01};
      vecs[5] = '{16'hFF80, 8'hFF};
      vecs[6] = '{16'hFE80, 8'hFF};
      vecs[7] = '{16'h01FF, 8'h02};
`else
      vecs[0] = '{16'h1280, 8'h12};
      vecs[1] = '{16'hFFC0, 8'hFF};
      vecs[2] = '{16'h0000, 8'h00};
      vecs[3] = '{16'h007F, 8'h00};
      vecs[4] = '{16'h0080, 8'h00};
      vecs[5] = '{16'hFF80, 8'hFF};
      vecs[6] = '{16'hFE80, 8'hFE};
      vecs[7] = '{16'h01FF, 8'h01};
`endif

      rst = 1'b1;
      i_start = 1'b0;
      i_base_addr = '0;
      i_num_pixels = '0;
      i_p_final_q = '0;
      i_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset we", o_mem_we, 0);
      check("reset addr", o_mem_addr, 0);
      check("reset wdata", o_mem_wdata, 0);
      check("reset be", o_mem_be, 0);
      check("reset busy", o_busy, 0);
      check("reset done", o_done, 0);
      check("reset drop", o_drop, 0);
      rst = 1'b0;

      // Base 0x0100, 8 pixels back to back.
      stim_vals.delete();
      for (int i = 1; i <= 8; i++) stim_vals.push_back(16'(i * 256));
      run_frame(16'h0100, 8, 0, 1'b0);
      if (wr_q.size() >= 2) begin
         check("plan1 word0", {wr_q[0].addr, wr_q[0].data, wr_q[0].be},
               {16'h0100, 32'h04030201, 4'hF});
         check("plan1 word1", {wr_q[1].addr, wr_q[1].data, wr_q[1].be},
               {16'h0101, 32'h08070605, 4'hF});
      end

      // Six pixels, one valid every three cycles: partial final word.
      run_frame(16'h0100, 6, 1, 1'b0);
      if (wr_q.size() >= 2) begin
         check("plan2 word1 addr", wr_q[1].addr, 16'h0101);
         check("plan2 word1 be", wr_q[1].be, 4'h3);
         check("plan2 word1 upper", wr_q[1].data[31:16], 16'h0000);
      end

      // Conversion table, one single-pixel frame per vector.
      foreach (vecs[i]) begin
         stim_vals.delete();
         stim_vals.push_back(vecs[i].q);
         run_frame(16'h2000 + 16'(i), 1, 0, 1'b0);
         if (wr_q.size() >= 1) begin
            check("conv byte", wr_q[0].data[7:0], vecs[i].exp);
            check("conv be", wr_q[0].be, 4'h1);
         end
      end

      // Address wrap from 0xFFFF.
      stim_vals.delete();
      for (int i = 0; i < 8; i++) stim_vals.push_back(16'($urandom_range(0, 65535)));
      run_frame(16'hFFFF, 8, 0, 1'b0);
      if (wr_q.size() >= 2) begin
         check("wrap addr0", wr_q[0].addr, 16'hFFFF);
         check("wrap addr1", wr_q[1].addr, 16'h0000);
      end

      // Valid pixels while idle (also beyond the end of a frame).
      wr_q.delete();
      @(negedge clk);
      i_valid = 1'b1;
      i_p_final_q = 16'h5500;
      repeat (3) @(negedge clk);
      i_valid = 1'b0;
      #1;
      check("idle drop", o_drop, 1);
      check("idle no write", wr_q.size(), 0);
      // Start with a pixel in the start cycle: that pixel is dropped too.
      stim_vals.delete();
      stim_vals.push_back(16'h3300);
      stim_vals.push_back(16'h4400);
      run_frame(16'h0500, 2, 0, 1'b1);
      // A clean start clears the flag; an empty frame writes nothing.
      run_frame(16'h0600, 0, 0, 1'b0);
      check("empty frame no write", wr_q.size(), 0);

      // Reset after three of four pixels.
      wr_q.delete();
      @(negedge clk);
      i_start = 1'b1;
      i_base_addr = 16'h0040;
      i_num_pixels = 18'd4;
      @(negedge clk);
      i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1;
         i_p_final_q = 16'(16'h1100 * (i + 1));
         @(negedge clk);
      end
      i_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("midrst we", o_mem_we, 0);
      check("midrst addr", o_mem_addr, 0);
      check("midrst wdata", o_mem_wdata, 0);
      check("midrst be", o_mem_be, 0);
      check("midrst busy", o_busy, 0);
      check("midrst done", o_done, 0);
      check("midrst drop", o_drop, 0);
      check("midrst no write", wr_q.size(), 0);
      rst = 1'b0;
      stim_vals.delete();
      for (int i = 0; i < 4; i++) stim_vals.push_back(16'(16'h2100 + i * 16'h0101));
      run_frame(16'h0040, 4, 0, 1'b0);

      // Random frames against the model.
      for (int f = 0; f < 25; f++) begin
         cnt = $urandom_range(0, 20);
         b = (f % 5 == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
         stim_vals.delete();
         for (int i = 0; i < cnt; i++) stim_vals.push_back(16'($urandom_range(0, 65535)));
         run_frame(b, cnt, (f % 3 == 0) ? 0 : 2, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
